// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: decodes a one-hot mode vector plus opcode into an ALU select,
// holds it behind a valid/ready handshake and sequences multi-beat ops.
module alu_ctrl_seq #(
    parameter int OP_W   = 5,
    parameter int SEL_W  = 3,
    parameter int SEL_M1 = 0,
    parameter int SEL_M2 = 4,
    parameter int SEL_M3 = 7,
    parameter int SEL_M4 = 4,
    parameter int MC_SEL = 6,
    parameter int ITER_N = 4,
    parameter int CNT_W  = $clog2(ITER_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op_code,
    input  logic [4:0]       alu_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel,
    output logic [CNT_W-1:0] out_beat,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam logic [SEL_W-1:0] SEL_M1_C  = SEL_W'(SEL_M1);
    localparam logic [SEL_W-1:0] SEL_M2_C  = SEL_W'(SEL_M2);
    localparam logic [SEL_W-1:0] SEL_M3_C  = SEL_W'(SEL_M3);
    localparam logic [SEL_W-1:0] SEL_M4_C  = SEL_W'(SEL_M4);
    localparam logic [SEL_W-1:0] MC_SEL_C  = SEL_W'(MC_SEL);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ITER_N - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] dec_sel;
    logic             dec_legal;
    logic             dec_multi;
    logic             accept;
    logic             complete;
    logic [CNT_W-1:0] beat_inc;
    logic             unused_op_hi;

    // Only the low SEL_W opcode bits matter; the rest are deliberately ignored.
    assign unused_op_hi = ^op_code;

    // Mode decode: R-type passes opcode bits through, other modes use fixed selects.
    always_comb begin
        dec_sel   = '0;
        dec_legal = 1'b1;
        dec_multi = 1'b0;
        case (alu_code)
            5'b00001: begin
                dec_sel   = op_code[SEL_W-1:0];
                dec_multi = (op_code[SEL_W-1:0] == MC_SEL_C);
            end
            5'b00010: dec_sel = SEL_M1_C;
            5'b00100: dec_sel = SEL_M2_C;
            5'b01000: dec_sel = SEL_M3_C;
            5'b10000: dec_sel = SEL_M4_C;
            default:  dec_legal = 1'b0;
        endcase
    end

    assign out_valid = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign out_sel   = sel_q;
    assign out_beat  = beat_q;
    assign out_last  = last_q;
    assign err       = err_q;
    assign complete  = out_valid & out_ready & last_q;
    // Flush blocks acceptance so a request in the flush cycle is simply ignored.
    assign in_ready  = ~flush & ((state_q == S_IDLE) | complete);
    assign accept    = in_valid & in_ready;
    assign beat_inc  = beat_q + CNT_W'(1);

    // Next-state logic: beat sequencing, op loading, error pulse and flush.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        beat_d  = beat_q;
        last_d  = last_q;
        err_d   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            beat_d  = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            state_d = S_ISSUE;
                            sel_d   = dec_sel;
                            beat_d  = '0;
                            last_d  = ~dec_multi;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (out_ready) begin
                        if (!last_q) begin
                            beat_d = beat_inc;
                            last_d = (beat_inc == LAST_BEAT);
                        end else if (accept && dec_legal) begin
                            // Back-to-back: next op's first beat follows without a bubble.
                            sel_d  = dec_sel;
                            beat_d = '0;
                            last_d = ~dec_multi;
                        end else begin
                            state_d = S_IDLE;
                            beat_d  = '0;
                            last_d  = 1'b0;
                            err_d   = accept;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule
